// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller slice.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [31:0] IRQ_VECTOR = 32'd240;

    // Cause index width for a given source count; never narrower than one bit.
    function automatic int cause_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Trap-side handshake between the interrupt controller and the CSR/trap stage.
interface irq_controller_if #(
    parameter int CAUSE_W = 2
);
    logic               stall;
    logic               mret;
    logic               interrupt;
    logic [CAUSE_W-1:0] irq_cause;
    logic [31:0]        vector;
    logic               in_service;

    // Controller side: requests traps, observes pipeline stall and handler return.
    modport master (
        input  stall, mret,
        output interrupt, irq_cause, vector, in_service
    );

    // CSR/trap stage side.
    modport slave (
        output stall, mret,
        input  interrupt, irq_cause, vector, in_service
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: index 0 has the highest priority.
module irq_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt initiator: edge-latches IRQ lines, picks one by fixed priority,
// issues a single-cycle trap request and waits for mret before the next one.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_SRC = 4,
    parameter int          CAUSE_W = 2,
    parameter logic [31:0] VECTOR  = IRQ_VECTOR
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_SRC-1:0]   irq_src,
    input  logic [NUM_SRC-1:0]   irq_en,
    input  logic                 mie,
    irq_controller_if.master     trap,
    output logic [NUM_SRC-1:0]   pending
);

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   src_q;
    logic [NUM_SRC-1:0]   pend_set;
    logic [NUM_SRC-1:0]   pend_clr;
    logic [NUM_SRC-1:0]   eligible;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic [CAUSE_W-1:0]   win_idx;
    logic                 win_vld;
    logic                 dispatch;

    assign pend_set = irq_src & ~src_q;
    assign eligible = pending & irq_en;

    // The trap is taken on the first unstalled ISSUE cycle.
    assign dispatch = (state_q == ISSUE) && !trap.stall;
    assign pend_clr = dispatch ? (NUM_SRC'(1) << cause_q) : '0;

    irq_prio_enc #(
        .N (NUM_SRC),
        .W (CAUSE_W)
    ) u_prio (
        .req   (eligible),
        .idx   (win_idx),
        .valid (win_vld)
    );

    // Edge-detect history; cleared on reset so a line high at release counts as an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) src_q <= '0;
        else          src_q <= irq_src;
    end

    // Pending events: a new edge on the same bit beats the dispatch clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending <= '0;
        else          pending <= (pending & ~pend_clr) | pend_set;
    end

    // State and latched cause registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next-state: arbitrate in IDLE, hold through stalls in ISSUE, wait for mret in SERVICE.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (mie && win_vld) begin
                    state_d = ISSUE;
                    cause_d = win_idx;
                end
            end
            ISSUE: begin
                if (!trap.stall) state_d = SERVICE;
            end
            SERVICE: begin
                if (trap.mret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign trap.interrupt  = dispatch;
    assign trap.irq_cause  = cause_q;
    assign trap.vector     = VECTOR;
    assign trap.in_service = (state_q == SERVICE);

endmodule
